// File: rtl/sincronizador_antirrebote.sv
// Per-channel input synchronizer and debouncer with edge pulses.
// Each channel settles its output only after a sustained change on its synchronized input.
module sincronizador_antirrebote_canal #(
  parameter int   ETAPAS_SYNC    = 2,
  parameter int   CICLOS_ESTABLE = 16,
  parameter logic VALOR_RESET    = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_asinc,
  input  logic i_hab,
  output logic o_sinc,
  output logic o_sube,
  output logic o_baja
);
  localparam int            CW     = $clog2(CICLOS_ESTABLE + 1);
  localparam logic [CW-1:0] LIMITE = CW'(CICLOS_ESTABLE - 1);

  logic [ETAPAS_SYNC-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_sinc, r_sube, r_baja;
  logic                   w_sinc, w_difiere;

  assign w_sinc    = r_sync[ETAPAS_SYNC-1];
  assign w_difiere = w_sinc != r_sinc;

  // The sync chain keeps running even while the channel is disabled.
  always_ff @(posedge clk or posedge reset)
    if (reset) r_sync <= {ETAPAS_SYNC{VALOR_RESET}};
    else       r_sync <= {r_sync[ETAPAS_SYNC-2:0], i_asinc};

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_cnt  <= '0;
      r_sinc <= VALOR_RESET;
      r_sube <= 1'b0;
      r_baja <= 1'b0;
    end else begin
      r_sube <= 1'b0;
      r_baja <= 1'b0;
      if (i_hab) begin
        if (!w_difiere)
          r_cnt <= '0;
        else if (r_cnt == LIMITE) begin
          r_cnt  <= '0;
          r_sinc <= w_sinc;
          r_sube <= w_sinc;
          r_baja <= ~w_sinc;
        end else
          r_cnt <= r_cnt + 1'b1;
      end
    end

  assign o_sinc = r_sinc;
  assign o_sube = r_sube;
  assign o_baja = r_baja;
endmodule

module sincronizador_antirrebote #(
  parameter int                     NUM_CANALES    = 4,
  parameter int                     ETAPAS_SYNC    = 2,
  parameter int                     CICLOS_ESTABLE = 16,
  parameter logic [NUM_CANALES-1:0] VALOR_RESET    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CANALES-1:0] senales_asincronas,
  input  logic [NUM_CANALES-1:0] habilitar,
  output logic [NUM_CANALES-1:0] senales_sincronas,
  output logic [NUM_CANALES-1:0] pulso_subida,
  output logic [NUM_CANALES-1:0] pulso_bajada
);
  for (genvar i = 0; i < NUM_CANALES; i++) begin : g_canal
    sincronizador_antirrebote_canal #(
      .ETAPAS_SYNC   (ETAPAS_SYNC),
      .CICLOS_ESTABLE(CICLOS_ESTABLE),
      .VALOR_RESET   (VALOR_RESET[i])
    ) u_canal (
      .clk    (clk),
      .reset  (reset),
      .i_asinc(senales_asincronas[i]),
      .i_hab  (habilitar[i]),
      .o_sinc (senales_sincronas[i]),
      .o_sube (pulso_subida[i]),
      .o_baja (pulso_bajada[i])
    );
  end
endmodule
